// File: rtl/eth_tx_arb.sv
// eth_tx_arb: two-requester AXI-Stream frame arbiter for one 10G MAC TX port.
// Frames are never interleaved; the inter-frame gap is optional (ETH_TX_ARB_IFG_EN).
//
// Parameters:
//   DATA_W     - tdata width, tkeep is DATA_W/8
//   IFG_CYCLES - idle cycles after each frame (only with ETH_TX_ARB_IFG_EN)
// Ports:
//   clk156, eth_rst_n (sync, active-low)
//   s0_axis_*, s1_axis_* - requester frame streams (slave side)
//   m_axis_*             - shared MAC TX stream (master side)
//   grant                - one-hot owner of m_axis, 2'b00 when none
//   frame_cnt0/1         - completed frames per requester, wrapping
module eth_tx_arb #(
    parameter int          DATA_W     = 64,
    parameter logic [15:0] IFG_CYCLES = 16'd12
) (
    input  logic                clk156,
    input  logic                eth_rst_n,

    input  logic                s0_axis_tvalid,
    output logic                s0_axis_tready,
    input  logic [DATA_W-1:0]   s0_axis_tdata,
    input  logic [DATA_W/8-1:0] s0_axis_tkeep,
    input  logic                s0_axis_tlast,
    input  logic                s0_axis_tuser,

    input  logic                s1_axis_tvalid,
    output logic                s1_axis_tready,
    input  logic [DATA_W-1:0]   s1_axis_tdata,
    input  logic [DATA_W/8-1:0] s1_axis_tkeep,
    input  logic                s1_axis_tlast,
    input  logic                s1_axis_tuser,

    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tuser,

    output logic [1:0]          grant,
    output logic [15:0]         frame_cnt0,
    output logic [15:0]         frame_cnt1
);

`ifdef ETH_TX_ARB_IFG_EN
    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
    logic [15:0] gap_cnt;
`else
    typedef enum logic [1:0] {IDLE, XFER} state_t;
    logic ifg_unused;
    assign ifg_unused = ^IFG_CYCLES;
`endif

    state_t     state;
    logic       rr;
    logic [1:0] req;
    logic       xfer;
    logic       last_beat;

    assign req       = {s1_axis_tvalid, s0_axis_tvalid};
    assign xfer      = (state == XFER);
    assign last_beat = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Zero-latency datapath; everything is forced low outside XFER.
    always_comb begin
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tkeep   = '0;
        m_axis_tlast   = 1'b0;
        m_axis_tuser   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        unique case (1'b1)
            xfer && grant[0]: begin
                m_axis_tvalid  = s0_axis_tvalid;
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tkeep   = s0_axis_tkeep;
                m_axis_tlast   = s0_axis_tlast;
                m_axis_tuser   = s0_axis_tuser;
                s0_axis_tready = m_axis_tready;
            end
            xfer && grant[1]: begin
                m_axis_tvalid  = s1_axis_tvalid;
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tkeep   = s1_axis_tkeep;
                m_axis_tlast   = s1_axis_tlast;
                m_axis_tuser   = s1_axis_tuser;
                s1_axis_tready = m_axis_tready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (!eth_rst_n) begin
            state      <= IDLE;
            grant      <= 2'b00;
            rr         <= 1'b0;
            frame_cnt0 <= 16'h0000;
            frame_cnt1 <= 16'h0000;
`ifdef ETH_TX_ARB_IFG_EN
            gap_cnt    <= 16'h0000;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        state <= XFER;
                        unique case (req)
                            2'b01:   grant <= 2'b01;
                            2'b10:   grant <= 2'b10;
                            default: grant <= rr ? 2'b10 : 2'b01;
                        endcase
                    end
                end
                XFER: begin
                    if (last_beat) begin
                        // Owner 0 hands priority to 1 and vice versa.
                        rr    <= grant[0];
                        grant <= 2'b00;
                        if (grant[0])
                            frame_cnt0 <= frame_cnt0 + 16'd1;
                        else
                            frame_cnt1 <= frame_cnt1 + 16'd1;
`ifdef ETH_TX_ARB_IFG_EN
                        gap_cnt <= IFG_CYCLES;
                        state   <= (IFG_CYCLES == 16'd0) ? IDLE : GAP;
`else
                        state   <= IDLE;
`endif
                    end
                end
`ifdef ETH_TX_ARB_IFG_EN
                GAP: begin
                    // Counts down from IFG_CYCLES; leaves on the last gap cycle.
                    if (gap_cnt <= 16'd1) begin
                        gap_cnt <= 16'h0000;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb_eth_tx_arb: directed/random bench for eth_tx_arb.
// Sources and expected streams are queues; ownership is checked per cycle.
module tb_eth_tx_arb;
    localparam int DW = 64;
    localparam int KW = DW / 8;
`ifdef ETH_TX_ARB_IFG_EN
    localparam int GAP = 12;
`else
    localparam int GAP = 0;
`endif

    logic          clk156 = 1'b0;
    logic          eth_rst_n;
    logic          s0_axis_tvalid, s0_axis_tready;
    logic [DW-1:0] s0_axis_tdata;
    logic [KW-1:0] s0_axis_tkeep;
    logic          s0_axis_tlast, s0_axis_tuser;
    logic          s1_axis_tvalid, s1_axis_tready;
    logic [DW-1:0] s1_axis_tdata;
    logic [KW-1:0] s1_axis_tkeep;
    logic          s1_axis_tlast, s1_axis_tuser;
    logic          m_axis_tvalid, m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast, m_axis_tuser;
    logic [1:0]    grant;
    logic [15:0]   frame_cnt0, frame_cnt1;

    eth_tx_arb #(.DATA_W(DW), .IFG_CYCLES(16'd12)) dut (
        .clk156(clk156), .eth_rst_n(eth_rst_n),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
        .s0_axis_tlast(s0_axis_tlast), .s0_axis_tuser(s0_axis_tuser),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
        .s1_axis_tlast(s1_axis_tlast), .s1_axis_tuser(s1_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .grant(grant), .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1)
    );

    always #3 clk156 = ~clk156;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic          u;
    } beat_t;

    beat_t src0[$], src1[$], exp0[$], exp1[$];
    int    owners[$], gaps[$], fstart[$];
    int    tests = 0, fails = 0, cyc = 0;
    int    start0 = 0, start1 = 0;
    int    mid = -1, tlast_cyc = -1;
    bit    rnd_rdy = 1'b0;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mkframe(int who, int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = {$urandom, $urandom};
            b.k = KW'($urandom);
            b.l = (i == n - 1);
            b.u = 1'($urandom_range(0, 1));
            if (who == 0) begin
                src0.push_back(b);
                exp0.push_back(b);
            end else begin
                src1.push_back(b);
                exp1.push_back(b);
            end
        end
    endtask

    task automatic clr();
        owners.delete();
        gaps.delete();
        fstart.delete();
        tlast_cyc = -1;
    endtask

    task automatic drive();
        beat_t b0, b1;
        logic  v0, v1;
        v0 = (src0.size() > 0) && (cyc >= start0);
        v1 = (src1.size() > 0) && (cyc >= start1);
        b0 = v0 ? src0[0] : '0;
        b1 = v1 ? src1[0] : '0;
        s0_axis_tvalid = v0;
        s0_axis_tdata  = b0.d;
        s0_axis_tkeep  = b0.k;
        s0_axis_tlast  = b0.l;
        s0_axis_tuser  = b0.u;
        s1_axis_tvalid = v1;
        s1_axis_tdata  = b1.d;
        s1_axis_tkeep  = b1.k;
        s1_axis_tlast  = b1.l;
        s1_axis_tuser  = b1.u;
        m_axis_tready  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic monitor();
        int    idx;
        beat_t b, e;
        if (!eth_rst_n) return;
        chk("grant_onehot0", 128'($onehot0(grant)), 128'd1);
        if (mid >= 0)
            chk("owner_kept", grant, (mid == 0) ? 2'b01 : 2'b10);
        if (grant == 2'b00) begin
            chk("idle_m_tvalid", m_axis_tvalid, 1'b0);
            chk("idle_s_tready", {s1_axis_tready, s0_axis_tready}, 2'b00);
            chk("idle_m_tdata", m_axis_tdata, '0);
            chk("idle_m_tkeep", m_axis_tkeep, '0);
            return;
        end
        idx = grant[1] ? 1 : 0;
        chk("m_tvalid_pass", m_axis_tvalid,
            idx ? s1_axis_tvalid : s0_axis_tvalid);
        chk("owner_tready", idx ? s1_axis_tready : s0_axis_tready,
            m_axis_tready);
        chk("other_tready", idx ? s0_axis_tready : s1_axis_tready, 1'b0);
        if (m_axis_tvalid && m_axis_tready) begin
            b = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            e = '0;
            if (idx == 0) begin
                chk("exp0_pending", exp0.size() > 0, 1'b1);
                if (exp0.size() > 0) e = exp0.pop_front();
            end else begin
                chk("exp1_pending", exp1.size() > 0, 1'b1);
                if (exp1.size() > 0) e = exp1.pop_front();
            end
            chk("beat_data", b, e);
            if (mid < 0) begin
                fstart.push_back(cyc);
                gaps.push_back(tlast_cyc >= 0 ? cyc - tlast_cyc - 1 : -1);
                mid = idx;
            end
            if (b.l) begin
                owners.push_back(idx);
                mid = -1;
                tlast_cyc = cyc;
            end
        end
    endtask

    task automatic step();
        bit h0, h1;
        @(negedge clk156);
        drive();
        #1;
        monitor();
        h0 = s0_axis_tvalid && s0_axis_tready && eth_rst_n;
        h1 = s1_axis_tvalid && s1_axis_tready && eth_rst_n;
        @(posedge clk156);
        if (h0) void'(src0.pop_front());
        if (h1) void'(src1.pop_front());
        cyc++;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((src0.size() > 0 || src1.size() > 0 || mid >= 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_in_budget", n < budget, 1'b1);
        repeat (GAP + 2) step();
        chk("exp_empty", exp0.size() + exp1.size(), 0);
    endtask

    task automatic do_reset();
        eth_rst_n = 1'b0;
        src0.delete(); src1.delete();
        exp0.delete(); exp1.delete();
        mid = -1;
        repeat (2) step();
        eth_rst_n = 1'b1;
    endtask

    initial begin
        int n;
        eth_rst_n = 1'b0;
        drive();
        repeat (3) step();
        chk("rst_grant", grant, 2'b00);
        chk("rst_cnt0", frame_cnt0, 16'h0);
        chk("rst_cnt1", frame_cnt1, 16'h0);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        eth_rst_n = 1'b1;

        // Lone s0 frame: one arbitration cycle, then 6 beats.
        clr();
        mkframe(0, 6);
        start0 = cyc;
        drain(60);
        chk("t1_arb_latency", fstart.size() > 0 ? fstart[0] : -1, start0 + 1);
        chk("t1_cnt0", frame_cnt0, 16'd1);
        chk("t1_owner", owners.size() == 1 && owners[0] == 0, 1'b1);

        // After s0 finished, s1 must win a tie.
        clr();
        mkframe(0, 1);
        mkframe(1, 1);
        start0 = cyc;
        start1 = cyc;
        drain(60);
        chk("t1_rr_first", owners.size() > 0 ? owners[0] : -1, 1);
        chk("t1_rr_second", owners.size() > 1 ? owners[1] : -1, 0);

        // Contention: 4 x 3-beat frames each, strict alternation from rr=0.
        do_reset();
        clr();
        for (int i = 0; i < 4; i++) begin
            mkframe(0, 3);
            mkframe(1, 3);
        end
        start0 = cyc;
        start1 = cyc;
        drain(300);
        chk("t2_nframes", owners.size(), 8);
        for (int k = 0; k < 8; k++)
            chk("t2_alternate", k < owners.size() ? owners[k] : -1, k % 2);
        chk("t2_cnt0", frame_cnt0, 16'd4);
        chk("t2_cnt1", frame_cnt1, 16'd4);

        // Random backpressure, s0 shows up while s1 owns the port.
        clr();
        rnd_rdy = 1'b1;
        mkframe(1, 8);
        mkframe(0, 4);
        start1 = cyc;
        start0 = cyc + 3;
        drain(400);
        rnd_rdy = 1'b0;
        chk("t3_nframes", owners.size(), 2);
        chk("t3_first_s1", owners.size() > 0 ? owners[0] : -1, 1);
        chk("t3_then_s0", owners.size() > 1 ? owners[1] : -1, 0);
        chk("t3_cnt1", frame_cnt1, 16'd5);

        // Back-to-back s0 frames: idle beats = gap + arbitration cycle.
        clr();
        for (int i = 0; i < 3; i++) mkframe(0, 2);
        start0 = cyc;
        drain(200);
        chk("t4_nframes", owners.size(), 3);
        chk("t4_gap1", gaps.size() > 1 ? gaps[1] : -1, GAP + 1);
        chk("t4_gap2", gaps.size() > 2 ? gaps[2] : -1, GAP + 1);

        // Reset in the middle of a frame.
        do_reset();
        clr();
        mkframe(0, 6);
        start0 = cyc;
        n = 0;
        while (exp0.size() > 3 && n < 50) begin
            step();
            n++;
        end
        chk("t5_reach_beat3", exp0.size(), 3);
        eth_rst_n = 1'b0;
        step();
        #1;
        chk("t5_m_tvalid", m_axis_tvalid, 1'b0);
        chk("t5_grant", grant, 2'b00);
        chk("t5_cnt0", frame_cnt0, 16'h0);
        src0.delete();
        exp0.delete();
        mid = -1;
        eth_rst_n = 1'b1;
        clr();
        mkframe(0, 6);
        start0 = cyc;
        drain(60);
        chk("t5_resume_latency", fstart.size() > 0 ? fstart[0] : -1, start0 + 1);
        chk("t5_cnt0_after", frame_cnt0, 16'd1);

        // Counter wrap, starting two frames short of rollover.
        force dut.frame_cnt1 = 16'hFFFE;
        step();
        release dut.frame_cnt1;
        step();
        clr();
        mkframe(1, 1);
        start1 = cyc;
        drain(40);
        chk("t6_cnt1_ffff", frame_cnt1, 16'hFFFF);
        mkframe(1, 1);
        start1 = cyc;
        drain(40);
        chk("t6_cnt1_wrap", frame_cnt1, 16'h0000);
        chk("t6_cnt0_same", frame_cnt0, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/eth_tx_arb.md
ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 Parameter DATA_W, default 64: AXI-Stream tdata width; tkeep width is DATA_W/8.
REQ-002 Parameter IFG_CYCLES, default 16'd12: idle cycles inserted after each frame when ETH_TX_ARB_IFG_EN is defined.
REQ-003 Port clk156, input, 1: the single clock; all logic is rising-edge.
REQ-004 Port eth_rst_n, input, 1: reset; synchronous and active-low.
REQ-005 Ports s0_axis_tvalid/tready/tdata/tkeep/tlast/tuser: in/out/in/in/in/in, widths 1/1/DATA_W/DATA_W/8/1/1; requester 0 frame stream.
REQ-006 Ports s1_axis_tvalid/tready/tdata/tkeep/tlast/tuser: same directions and widths as s0; requester 1 frame stream.
REQ-007 Ports m_axis_tvalid/tready/tdata/tkeep/tlast/tuser: out/in/out/out/out/out, same widths; shared 10G MAC TX stream.
REQ-008 Port grant, output, 2: one-hot owner of m_axis; 2'b00 when no owner.
REQ-009 Ports frame_cnt0 and frame_cnt1, output, 16 each: frames completed per requester.

Function
REQ-010 The block SHALL contain the states IDLE, XFER and GAP, with GAP present only under ETH_TX_ARB_IFG_EN.
REQ-011 In IDLE, if exactly one sN_axis_tvalid is high, that requester SHALL be granted on the next edge.
REQ-012 In IDLE, if both tvalids are high, the requester indicated by the 1-bit round-robin pointer `rr` SHALL be granted.
REQ-013 On a grant the block SHALL register grant, enter XFER and assert nothing on m_axis in the granting cycle, giving 1-cycle arbitration latency.
REQ-014 In XFER, m_axis tvalid/tdata/tkeep/tlast/tuser SHALL combinationally equal the granted slave's signals, with 0-cycle datapath latency.
REQ-015 In XFER, the granted sN_axis_tready SHALL equal m_axis_tready, and the non-granted tready SHALL be 0.
REQ-016 Outside XFER, m_axis_tvalid and both s tready outputs SHALL be 0; m_axis_tdata/tkeep SHALL be 0, with no X on the output.
REQ-017 A grant SHALL be held until a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast; the owner never changes mid-frame.
REQ-018 On that last beat, `rr` SHALL be set to the non-granted index, frame_cntN of the owner SHALL increment, grant SHALL clear to 2'b00, and the next state SHALL be GAP (macro defined) or IDLE (macro undefined).
REQ-019 frame_cnt0 and frame_cnt1 SHALL wrap from 16'hFFFF to 16'h0000 without a flag.
REQ-020 tvalid deasserting mid-frame on the owner SHALL stall in XFER, and ownership SHALL be kept.
REQ-021 tvalid rising on the other requester during XFER SHALL be ignored until the next IDLE evaluation.
REQ-022 A single-beat frame (tlast on the first beat) SHALL complete in XFER in one cycle, following REQ-018.

Reset
REQ-023 While eth_rst_n=0 at a clk156 edge: state=IDLE, grant=2'b00, rr=0, frame_cnt0=frame_cnt1=0, and the gap counter SHALL be 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame; m_axis_tvalid SHALL be 0 in the first cycle after the reset edge, no tlast SHALL be generated, and the counter SHALL NOT increment.
REQ-025 After reset release, arbitration SHALL resume from IDLE per REQ-011/REQ-012 on the first cycle.

Configuration
REQ-026 Macro ETH_TX_ARB_IFG_EN defined: after each frame the block SHALL sit in GAP for exactly IFG_CYCLES cycles (16-bit counter, tready/tvalid low), then enter IDLE; IFG_CYCLES=0 SHALL behave as a direct return to IDLE.
REQ-027 Macro ETH_TX_ARB_IFG_EN undefined: GAP and its counter SHALL be absent, and the block SHALL return to IDLE on the cycle after the last beat.

Verification
REQ-028 Reset, then s0 sends a 6-beat frame with m_axis_tready=1 -> grant=2'b01 one cycle after tvalid, 6 beats pass unchanged, frame_cnt0=1, rr=1.
REQ-029 s0 and s1 both hold valid frames of 3 beats, repeated 4 times each -> grants alternate 01,10,01,10..., and frame_cnt0=frame_cnt1=4.
REQ-030 Toggle m_axis_tready pseudo-randomly with 50% duty during an 8-beat s1 frame, and raise s0 tvalid at beat 2 -> no s0 beat is accepted before s1 tlast, and the data order is intact.
REQ-031 With ETH_TX_ARB_IFG_EN and IFG_CYCLES=12, run back-to-back s0 frames -> exactly 12 cycles of m_axis_tvalid=0 between tlast and the next grant cycle, plus 1 arbitration cycle.
REQ-032 Drive eth_rst_n=0 at beat 3 of a 6-beat frame -> next cycle m_axis_tvalid=0, grant=2'b00, frame_cnt unchanged at 0; after release a new frame passes normally.
REQ-033 Preload 65535 single-beat s1 frames, then send one more -> frame_cnt1 wraps to 16'h0000.
